input_mapper: RTL
=================

# input_mapper

Registered control-input stage between `hps_io` and the `Cave` core. It decodes PS/2 make/break events into a key table and merges the keys with both MiSTer joysticks. It then conditions the result into the per-player control vectors the core consumes. Conditioning covers coin pulse shaping, opposite-direction cleaning, latched pause and optional autofire.

## Interface
Parameters:
- `COIN_CYCLES`, default 4_800_000: length of the coin pulse in `clk_sys` cycles (about 50 ms at 96 MHz); must be ≥1.
- `AUTOFIRE_HALF`, default 3_200_000: autofire half-period in `clk_sys` cycles; must be ≥1.

Ports:
- `clk_sys`  in  1: system clock.
- `RESET`  in  1: reset, asynchronous, active-high.
- `ps2_key`  in  11: hps_io key event.
  - [10] is the event toggle.
  - [9] is pressed.
  - [8] is the extended flag and is ignored.
  - [7:0] is the scan code.
- `joystick_0`, `joystick_1`  in  32 each: hps_io joysticks.
  - [0] right, [1] left, [2] down, [3] up.
  - [7:4] buttons 1–4.
  - [8] start, [9] coin, [10] pause.
- `autofire`  in  1: autofire request (status bit); ignored unless AUTOFIRE_EN is defined.
- `p1_ctrl`, `p2_ctrl`  out  10 each: conditioned controls.
  - [0] right, [1] left, [2] down, [3] up.
  - [7:4] buttons 1–4.
  - [8] start, [9] coin.
- `pause`  out  1: latched pause state.

## Operation
- Key table, player 1:
  - 75 up, 72 down, 6B left, 74 right.
  - 14 button 1, 11 button 2, 29 button 3, 12 button 4.
  - 16 start, 2E coin, 4D pause.
- Key table, player 2:
  - 2D up, 2B down, 23 left, 34 right.
  - 1C button 1, 1B button 2, 15 button 3, 1D button 4.
  - 1E start, 36 coin; player 2 has no pause key.
- Key event handling:
  - An event is `ps2_key[10]` differing from its registered copy.
  - On an event, the entry matching `ps2_key[7:0]` is set to `ps2_key[9]`.
  - Unmatched codes are discarded.
- Priming: the first cycle after reset only samples `ps2_key[10]` (a `primed` flag), so a stale toggle level never produces an event.
- Raw control = key OR joystick bit, computed per signal.
- Direction cleaning: if up and down are both raw-high, both outputs are 0. The same rule applies to left and right.
- Coin:
  - A raw rising edge while the coin FSM is IDLE enters PULSE. The coin output is high for exactly `COIN_CYCLES` cycles.
  - The FSM then enters HOLD and stays there until raw coin is low, then returns to IDLE.
  - Edges during PULSE or HOLD are ignored. Each player has an independent FSM.
- Pause: a rising edge of (P1 pause OR P2 pause) toggles `pause`. Simultaneous edges from both players produce a single toggle.
- All other bits pass through the cleaning logic into the output register unchanged.

## Timing
- Reset values: every output is 0, the key table is 0, the coin FSMs are IDLE, counters are 0, `pause` is 0 and `primed` is 0.
- Latency:
  - Joystick change to output: 1 cycle.
  - PS/2 event to key table: 1 cycle; to output: 2 cycles.
- Coin: the output rises 1 cycle after the raw edge and falls exactly `COIN_CYCLES` cycles later.
- Counter widths are `$clog2(param+1)`. Counters never wrap; each reloads on state entry.
- Reset asserted mid-pulse or mid-autofire clears immediately. No pulse resumes after reset is released.

## Configuration
- `INPUT_MAPPER_AUTOFIRE_EN` defined:
  - While `autofire` is 1 and raw button 1 is held, output button 1 runs a square wave. It is high for the first `AUTOFIRE_HALF` cycles from the press, then alternates low and high with half-period `AUTOFIRE_HALF`.
  - Releasing the button forces the output low and resets the phase.
  - Each player has an independent generator.
- Undefined: no autofire logic is built, the `autofire` port is ignored, and button 1 is a steady pass-through.

## Structure
- Package `input_pkg`:
  - PS/2 scan-code localparams.
  - `ctrl_t` bit-index constants: RIGHT, LEFT, DOWN, UP, BTN1–BTN4, START, COIN.
  - Coin FSM enum: IDLE, PULSE, HOLD.
- Sub-module `coin_pulse`: one coin FSM plus counter, parameterised by `COIN_CYCLES`, instantiated twice.
- The autofire generator is inline and guarded by the macro.

## Test plan
- PS/2 make/break:
  - Set code 75, pressed=1, toggle [10] → `p1_ctrl[3]`=1 two cycles later.
  - Code 75, pressed=0, toggle → `p1_ctrl[3]`=0 two cycles later.
  - Changing code without a toggle → no change.
- Priming: hold `ps2_key`={toggle=1, pressed=1, code 2E} through reset release → `p1_ctrl[9]` stays 0.
- Coin, with `COIN_CYCLES`=16:
  - `joystick_1[9]` high for 40 cycles → `p2_ctrl[9]` high for exactly 16 cycles, no retrigger.
  - A second edge after release → a second 16-cycle pulse.
  - Reset at pulse cycle 5 → the output is 0 immediately.
- Cleaning: `joystick_0[3:2]`=11 → `p1_ctrl[3:2]`=00. Key 6B plus `joystick_0[0]` → `p1_ctrl[1:0]`=00.
- Pause:
  - `joystick_0[10]` pulse → `pause`=1; a second pulse → 0.
  - `joystick_0[10]` and `joystick_1[10]` rising in the same cycle → exactly one toggle.
- Autofire, with `AUTOFIRE_HALF`=4 and `autofire`=1, hold `joystick_0[4]`:
  - With the macro → `p1_ctrl[4]` runs 1111 0000 1111…; release → 0.
  - Without the macro → steady 1.

Source files
------------

// File: rtl/input_mapper_pkg.sv
// input_pkg -- shared constants for the input_mapper control stage.
//   * PS/2 set-2 scan codes for both players' key tables
//   * bit indices of the per-player control vector (ctrl_t)
//   * coin pulse FSM state encoding
//   * clean_dirs(): drops opposing direction pairs
package input_pkg;

   // player 1
   localparam logic [7:0] SC_P1_UP    = 8'h75;
   localparam logic [7:0] SC_P1_DOWN  = 8'h72;
   localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
   localparam logic [7:0] SC_P1_RIGHT = 8'h74;
   localparam logic [7:0] SC_P1_BTN1  = 8'h14;
   localparam logic [7:0] SC_P1_BTN2  = 8'h11;
   localparam logic [7:0] SC_P1_BTN3  = 8'h29;
   localparam logic [7:0] SC_P1_BTN4  = 8'h12;
   localparam logic [7:0] SC_P1_START = 8'h16;
   localparam logic [7:0] SC_P1_COIN  = 8'h2E;
   localparam logic [7:0] SC_P1_PAUSE = 8'h4D;
   // player 2 (no pause key)
   localparam logic [7:0] SC_P2_UP    = 8'h2D;
   localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
   localparam logic [7:0] SC_P2_LEFT  = 8'h23;
   localparam logic [7:0] SC_P2_RIGHT = 8'h34;
   localparam logic [7:0] SC_P2_BTN1  = 8'h1C;
   localparam logic [7:0] SC_P2_BTN2  = 8'h1B;
   localparam logic [7:0] SC_P2_BTN3  = 8'h15;
   localparam logic [7:0] SC_P2_BTN4  = 8'h1D;
   localparam logic [7:0] SC_P2_START = 8'h1E;
   localparam logic [7:0] SC_P2_COIN  = 8'h36;

   // ctrl_t bit indices; joystick bits [9:0] use the same layout
   localparam int RIGHT  = 0;
   localparam int LEFT   = 1;
   localparam int DOWN   = 2;
   localparam int UP     = 3;
   localparam int BTN1   = 4;
   localparam int BTN2   = 5;
   localparam int BTN3   = 6;
   localparam int BTN4   = 7;
   localparam int START  = 8;
   localparam int COIN   = 9;
   localparam int CTRL_W = 10;
   localparam int JOY_PAUSE = 10;

   typedef logic [CTRL_W-1:0] ctrl_t;

   typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_state_t;

   // Opposing directions held together cancel to neither.
   function automatic ctrl_t clean_dirs(input ctrl_t r);
      ctrl_t c;
      c = r;
      if (r[UP] && r[DOWN]) begin
         c[UP]   = 1'b0;
         c[DOWN] = 1'b0;
      end
      if (r[LEFT] && r[RIGHT]) begin
         c[LEFT]  = 1'b0;
         c[RIGHT] = 1'b0;
      end
      return c;
   endfunction

endpackage

// File: rtl/input_mapper_coin.sv
// coin_pulse -- one player's coin shaper.
// A rising edge of coin_raw (seen in IDLE) produces a registered high pulse of
// exactly COIN_CYCLES clocks; the FSM then waits in HOLD until coin_raw drops,
// so a held coin never retriggers.
// Ports:
//   clk_sys, RESET (async, active-high)
//   coin_raw  in  raw coin (key OR joystick)
//   coin_out  out shaped coin pulse
module coin_pulse
   import input_pkg::*;
#(
   parameter int COIN_CYCLES = 4_800_000
) (
   input  logic clk_sys,
   input  logic RESET,
   input  logic coin_raw,
   output logic coin_out
);

   localparam int CW = $clog2(COIN_CYCLES + 1);

   coin_state_t   state;
   logic [CW-1:0] cnt;
   logic          raw_q;

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         cnt      <= '0;
         raw_q    <= 1'b0;
         coin_out <= 1'b0;
      end else begin
         raw_q <= coin_raw;
         case (state)
            IDLE: if (coin_raw && !raw_q) begin
               state    <= PULSE;
               cnt      <= CW'(COIN_CYCLES);
               coin_out <= 1'b1;
            end
            // cnt holds the remaining high cycles including the current one
            PULSE: if (cnt == CW'(1)) begin
               state    <= HOLD;
               cnt      <= '0;
               coin_out <= 1'b0;
            end else begin
               cnt <= cnt - CW'(1);
            end
            HOLD: if (!coin_raw) state <= IDLE;
            default: begin
               state    <= IDLE;
               coin_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/input_mapper.sv
// input_mapper -- registered control stage between hps_io and the Cave core.
// Decodes PS/2 make/break events into a key table, ORs keys with the MiSTer
// joysticks, cleans opposing directions, shapes coin pulses, latches pause
// and (optionally) runs autofire on button 1.
// Optional feature: define INPUT_MAPPER_AUTOFIRE_EN to build the autofire
// generators; otherwise `autofire` is ignored and button 1 passes through.
// Ports:
//   clk_sys, RESET (async, active-high)
//   ps2_key    in  [10] toggle, [9] pressed, [8] extended (ignored), [7:0] code
//   joystick_0/1 in [3:0] R/L/D/U, [7:4] buttons, [8] start, [9] coin, [10] pause
//   autofire   in  autofire enable
//   p1_ctrl/p2_ctrl out conditioned controls (ctrl_t layout)
//   pause      out latched pause
module input_mapper
   import input_pkg::*;
#(
   parameter int COIN_CYCLES   = 4_800_000,
   parameter int AUTOFIRE_HALF = 3_200_000
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic [10:0] ps2_key,
   input  logic [31:0] joystick_0,
   input  logic [31:0] joystick_1,
   input  logic        autofire,
   output logic [9:0]  p1_ctrl,
   output logic [9:0]  p2_ctrl,
   output logic        pause
);

   logic [1:0][CTRL_W-1:0] keys, raw, clean, ctrl;
   logic                   p1_pause_key;
   logic                   primed, tog_q, ps2_evt;
   logic                   pause_raw, pause_raw_q;

   // ---------------- PS/2 key table ----------------
   // The first cycle after reset only captures the toggle level, so a toggle
   // left high across reset is not mistaken for a fresh event.
   assign ps2_evt = primed && (ps2_key[10] != tog_q);

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         primed       <= 1'b0;
         tog_q        <= 1'b0;
         keys         <= '0;
         p1_pause_key <= 1'b0;
      end else begin
         primed <= 1'b1;
         tog_q  <= ps2_key[10];
         if (ps2_evt) begin
            case (ps2_key[7:0])
               SC_P1_RIGHT: keys[0][RIGHT] <= ps2_key[9];
               SC_P1_LEFT:  keys[0][LEFT]  <= ps2_key[9];
               SC_P1_DOWN:  keys[0][DOWN]  <= ps2_key[9];
               SC_P1_UP:    keys[0][UP]    <= ps2_key[9];
               SC_P1_BTN1:  keys[0][BTN1]  <= ps2_key[9];
               SC_P1_BTN2:  keys[0][BTN2]  <= ps2_key[9];
               SC_P1_BTN3:  keys[0][BTN3]  <= ps2_key[9];
               SC_P1_BTN4:  keys[0][BTN4]  <= ps2_key[9];
               SC_P1_START: keys[0][START] <= ps2_key[9];
               SC_P1_COIN:  keys[0][COIN]  <= ps2_key[9];
               SC_P1_PAUSE: p1_pause_key   <= ps2_key[9];
               SC_P2_RIGHT: keys[1][RIGHT] <= ps2_key[9];
               SC_P2_LEFT:  keys[1][LEFT]  <= ps2_key[9];
               SC_P2_DOWN:  keys[1][DOWN]  <= ps2_key[9];
               SC_P2_UP:    keys[1][UP]    <= ps2_key[9];
               SC_P2_BTN1:  keys[1][BTN1]  <= ps2_key[9];
               SC_P2_BTN2:  keys[1][BTN2]  <= ps2_key[9];
               SC_P2_BTN3:  keys[1][BTN3]  <= ps2_key[9];
               SC_P2_BTN4:  keys[1][BTN4]  <= ps2_key[9];
               SC_P2_START: keys[1][START] <= ps2_key[9];
               SC_P2_COIN:  keys[1][COIN]  <= ps2_key[9];
               default: ;
            endcase
         end
      end
   end

   assign raw[0] = keys[0] | joystick_0[CTRL_W-1:0];
   assign raw[1] = keys[1] | joystick_1[CTRL_W-1:0];

   // ---------------- pause ----------------
   // Both players share one edge detector, so coincident presses toggle once.
   assign pause_raw = p1_pause_key | joystick_0[JOY_PAUSE] | joystick_1[JOY_PAUSE];

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         pause_raw_q <= 1'b0;
         pause       <= 1'b0;
      end else begin
         pause_raw_q <= pause_raw;
         if (pause_raw && !pause_raw_q) pause <= ~pause;
      end
   end

   // ---------------- per-player conditioning ----------------
   for (genvar p = 0; p < 2; p++) begin : g_player
      logic           coin_q;
      logic           b1_out;
      logic [START:0] out_q;

      assign clean[p] = clean_dirs(raw[p]);

      coin_pulse #(.COIN_CYCLES(COIN_CYCLES)) u_coin (
         .clk_sys  (clk_sys),
         .RESET    (RESET),
         .coin_raw (raw[p][COIN]),
         .coin_out (coin_q)
      );

`ifdef INPUT_MAPPER_AUTOFIRE_EN
      localparam int AW = $clog2(AUTOFIRE_HALF + 1);
      logic [AW-1:0] af_cnt;
      logic          af_ph;   // 0 = high half, 1 = low half
      logic          af_run;

      assign af_run = autofire & raw[p][BTN1];

      // Phase restarts in the high half whenever the button is released.
      always_ff @(posedge clk_sys or posedge RESET) begin
         if (RESET) begin
            af_cnt <= '0;
            af_ph  <= 1'b0;
         end else if (!af_run) begin
            af_cnt <= '0;
            af_ph  <= 1'b0;
         end else if (af_cnt == AW'(AUTOFIRE_HALF - 1)) begin
            af_cnt <= '0;
            af_ph  <= ~af_ph;
         end else begin
            af_cnt <= af_cnt + AW'(1);
         end
      end

      assign b1_out = clean[p][BTN1] & ~(autofire & af_ph);
`else
      assign b1_out = clean[p][BTN1];
`endif

      always_ff @(posedge clk_sys or posedge RESET) begin
         if (RESET) out_q <= '0;
         else       out_q <= {clean[p][START:BTN2], b1_out, clean[p][UP:RIGHT]};
      end

      assign ctrl[p] = {coin_q, out_q};
   end

`ifndef INPUT_MAPPER_AUTOFIRE_EN
   localparam int unused_af_half = AUTOFIRE_HALF;
   logic unused_af;
   assign unused_af = autofire;
`endif

   logic unused_bits;
   assign unused_bits = ^{ps2_key[8], joystick_0[31:11], joystick_1[31:11]};

   assign p1_ctrl = ctrl[0];
   assign p2_ctrl = ctrl[1];

endmodule
